// File: rtl/biriscv_csr_wb_pipe_pkg.sv
// Shared exception codes and stage payload for the CSR E1 -> E2 -> WB carrier.
// Codes mirror the values of the core-wide exception definitions.
package biriscv_csr_wb_pipe_pkg;

    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT          = 6'h13;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD          = 6'h15;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE         = 6'h17;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h34;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [31:0]            opcode;
        logic [4:0]             rd;
        logic [31:0]            value;
        logic                   write;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exc;
        logic [31:0]            addr;
    } csr_wb_payload_t;

    // A FENCE-tagged result (e.g. SATP write) still retires its CSR/GPR writes.
    function automatic logic exc_commits(input logic [EXCEPTION_W-1:0] exc);
        return (exc == '0) || (exc == EXCEPTION_FENCE);
    endfunction

endpackage

// File: rtl/biriscv_csr_wb_stage.sv
// Payload register with hold, bubble and kill; empty slots are held as all-zero
// so downstream outputs read 0 whenever the slot is invalid.
module biriscv_csr_wb_stage
    import biriscv_csr_wb_pipe_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_hold,
    input  logic            i_bubble,
    input  logic            i_kill,
    input  csr_wb_payload_t i_data,
    output csr_wb_payload_t o_data
);

    csr_wb_payload_t r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_kill) begin
            r_data <= '0;
        end else if (!i_hold) begin
            r_data <= (i_bubble || !i_data.valid) ? '0 : i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/biriscv_csr_wb_pipe.sv
// Carries CSR results E1 -> E2 -> WB, merges late LSU faults, and drives the
// CSR file writeback, GPR writeback, flush and CSR busy hazard flag.
module biriscv_csr_wb_pipe
    import biriscv_csr_wb_pipe_pkg::*;
#(
    parameter int SUPPORT_MEM_FAULT = 1
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [31:0] issue_pc_i,
    input  logic [31:0] issue_opcode_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [31:0] csr_result_e1_value_i,
    input  logic        csr_result_e1_write_i,
    input  logic [31:0] csr_result_e1_wdata_i,
    input  logic [5:0]  csr_result_e1_exception_i,
    input  logic        stall_i,
    input  logic        squash_e1_i,
    input  logic [5:0]  mem_fault_e2_i,
    input  logic [31:0] mem_fault_addr_e2_i,
    output logic        csr_writeback_write_o,
    output logic [11:0] csr_writeback_waddr_o,
    output logic [31:0] csr_writeback_wdata_o,
    output logic [5:0]  csr_writeback_exception_o,
    output logic [31:0] csr_writeback_exception_pc_o,
    output logic [31:0] csr_writeback_exception_addr_o,
    output logic        wb_rd_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_rd_value_o,
    output logic        flush_o,
    output logic        csr_busy_o
);

    logic            r_e1_valid;
    logic [31:0]     r_e1_pc;
    logic [31:0]     r_e1_opcode;
    logic [4:0]      r_e1_rd;
    csr_wb_payload_t w_e1;
    csr_wb_payload_t w_e2;
    csr_wb_payload_t w_wb_in;
    csr_wb_payload_t w_wb;
    logic            w_flush;
    logic            w_mem_fault;
    logic            w_commit;
    logic            w_unused;

    assign w_flush = w_wb.valid && (w_wb.exc != '0);

    // E1: issue sideband; the CSR unit's E1 results are joined combinationally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_e1_valid  <= 1'b0;
            r_e1_pc     <= '0;
            r_e1_opcode <= '0;
            r_e1_rd     <= '0;
        end else begin
            if (w_flush) begin
                r_e1_valid <= 1'b0;
            end else if (!stall_i) begin
                r_e1_valid <= issue_valid_i;
            end
            if (issue_valid_i && !stall_i && !w_flush) begin
                r_e1_pc     <= issue_pc_i;
                r_e1_opcode <= issue_opcode_i;
                r_e1_rd     <= issue_rd_idx_i;
            end
        end
    end

    always_comb begin
        w_e1        = '0;
        w_e1.valid  = r_e1_valid;
        w_e1.pc     = r_e1_pc;
        w_e1.opcode = r_e1_opcode;
        w_e1.rd     = r_e1_rd;
        w_e1.value  = csr_result_e1_value_i;
        w_e1.write  = csr_result_e1_write_i;
        w_e1.wdata  = csr_result_e1_wdata_i;
        w_e1.exc    = csr_result_e1_exception_i;
    end

    // E2: squash replaces the advancing E1 occupant with a bubble
    biriscv_csr_wb_stage u_e2 (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_hold   (stall_i),
        .i_bubble (squash_e1_i),
        .i_kill   (w_flush),
        .i_data   (w_e1),
        .o_data   (w_e2)
    );

    assign w_mem_fault = (SUPPORT_MEM_FAULT != 0) && (mem_fault_e2_i != '0);

    always_comb begin
        w_wb_in      = w_e2;
        w_wb_in.addr = '0;
        if (w_e2.exc != '0) begin
            case (w_e2.exc)
                EXCEPTION_ILLEGAL_INSTRUCTION: w_wb_in.addr = w_e2.value;
                EXCEPTION_BREAKPOINT:          w_wb_in.addr = w_e2.pc;
                default:                       w_wb_in.addr = '0;
            endcase
        end else if (w_mem_fault) begin
            w_wb_in.exc  = mem_fault_e2_i;
            w_wb_in.addr = mem_fault_addr_e2_i;
        end
    end

    // WB: a stall inserts a bubble so no instruction is presented twice
    biriscv_csr_wb_stage u_wb (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_hold   (1'b0),
        .i_bubble (stall_i),
        .i_kill   (w_flush),
        .i_data   (w_wb_in),
        .o_data   (w_wb)
    );

    assign w_commit = w_wb.valid && w_wb.write && exc_commits(w_wb.exc);

    assign csr_writeback_write_o          = w_commit;
    assign csr_writeback_waddr_o          = w_wb.opcode[31:20];
    assign csr_writeback_wdata_o          = w_wb.wdata;
    assign csr_writeback_exception_o      = w_wb.exc;
    assign csr_writeback_exception_pc_o   = w_wb.pc;
    assign csr_writeback_exception_addr_o = w_wb.addr;
    assign wb_rd_valid_o                  = w_commit && (w_wb.rd != '0);
    assign wb_rd_idx_o                    = w_wb.rd;
    assign wb_rd_value_o                  = w_wb.value;
    assign flush_o                        = w_flush;
    assign csr_busy_o = (r_e1_valid && csr_result_e1_write_i) ||
                        (w_e2.valid && w_e2.write) ||
                        (w_wb.valid && w_wb.write);

    assign w_unused = ^{w_wb.opcode[19:0], w_e2.addr};

endmodule
